// File: rtl/adder_cmd_seq.sv
// Command sequencer in front of the ASCII adder: parses "<d><op><d>" from RX, starts the adder, sends the result to TX.
// Ports: clk, Gl_rst (sync, active-high); rx_data/rx_valid in; adder_data/adder_rdy in; tx_busy in;
//   seq_r1/seq_r2/seq_subtract/seq_start to adder; tx_data/tx_valid out; seq_err sticky flag; seq_led status.
// Optional: define SEQ_CRLF_EN to follow each result with CR LF.
module adder_cmd_seq #(
  parameter int unsigned TIMEOUT_CYC = 15
) (
  input  logic       clk,
  input  logic       Gl_rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic [7:0] adder_data,
  input  logic       adder_rdy,
  input  logic       tx_busy,
  output logic [7:0] seq_r1,
  output logic [7:0] seq_r2,
  output logic       seq_subtract,
  output logic       seq_start,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       seq_err,
  output logic [7:0] seq_led
);

  localparam logic [7:0] TO = 8'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    GET_R1   = 3'd0,
    GET_OP   = 3'd1,
    GET_R2   = 3'd2,
    START    = 3'd3,
    WAIT_RDY = 3'd4,
`ifdef SEQ_CRLF_EN
    SEND     = 3'd5,
    CR       = 3'd6,
    LF       = 3'd7
`else
    SEND     = 3'd5
`endif
  } state_t;

  state_t     state, state_n;
  logic [7:0] r1_n, r2_n;
  logic       sub_n, err_n;
  logic [7:0] result, result_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic       is_digit, is_space, is_plus, is_minus;
  logic [2:0] state_bits;

  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign is_space = rx_data == 8'h20;
  assign is_plus  = rx_data == 8'h2B;
  assign is_minus = rx_data == 8'h2D;
  assign cnt_inc  = cnt + 8'd1;

  assign state_bits = state;
  assign seq_led    = {seq_err, state_bits, result[3:0]};

  always_ff @(posedge clk) begin
    if (Gl_rst) begin
      state        <= GET_R1;
      seq_r1       <= 8'h30;
      seq_r2       <= 8'h30;
      seq_subtract <= 1'b0;
      seq_err      <= 1'b0;
      result       <= 8'h30;
      cnt          <= 8'd0;
    end else begin
      state        <= state_n;
      seq_r1       <= r1_n;
      seq_r2       <= r2_n;
      seq_subtract <= sub_n;
      seq_err      <= err_n;
      result       <= result_n;
      cnt          <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    r1_n      = seq_r1;
    r2_n      = seq_r2;
    sub_n     = seq_subtract;
    err_n     = seq_err;
    result_n  = result;
    cnt_n     = cnt;
    seq_start = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    unique case (state)
      GET_R1: begin
        if (rx_valid && !is_space) begin
          if (is_digit) begin
            r1_n    = rx_data;
            state_n = GET_OP;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      GET_OP: begin
        if (rx_valid && !is_space) begin
          if (is_plus || is_minus) begin
            sub_n   = is_minus;
            state_n = GET_R2;
          end else begin
            err_n   = 1'b1;
            state_n = GET_R1;
          end
        end
      end
      GET_R2: begin
        if (rx_valid && !is_space) begin
          if (is_digit) begin
            r2_n    = rx_data;
            state_n = START;
          end else begin
            err_n   = 1'b1;
            state_n = GET_R1;
          end
        end
      end
      START: begin
        seq_start = 1'b1;
        cnt_n     = 8'd0;
        state_n   = WAIT_RDY;
      end
      WAIT_RDY: begin
        cnt_n = cnt_inc;
        // A ready pulse on the final wait cycle still counts as success.
        if (adder_rdy) begin
          result_n = adder_data;
          err_n    = 1'b0;
          state_n  = SEND;
        end else if (cnt_inc == TO) begin
          result_n = 8'h3F;
          err_n    = 1'b1;
          state_n  = SEND;
        end
      end
      SEND: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          tx_data  = result;
`ifdef SEQ_CRLF_EN
          state_n  = CR;
`else
          state_n  = GET_R1;
`endif
        end
      end
`ifdef SEQ_CRLF_EN
      CR: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          tx_data  = 8'h0D;
          state_n  = LF;
        end
      end
      LF: begin
        if (!tx_busy) begin
          tx_valid = 1'b1;
          tx_data  = 8'h0A;
          state_n  = GET_R1;
        end
      end
`endif
      default: state_n = GET_R1;
    endcase
  end

endmodule

// File: tb/tb_adder_cmd_seq.sv
// Scoreboard bench for adder_cmd_seq: directed commands, adder model, TX monitor.
// Expected TX bytes are queued at stimulus time and popped by the monitor.
module tb_adder_cmd_seq;

  localparam int TO = 15;

  logic       clk;
  logic       Gl_rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] adder_data;
  logic       adder_rdy;
  logic       tx_busy;
  logic [7:0] seq_r1, seq_r2;
  logic       seq_subtract, seq_start;
  logic [7:0] tx_data;
  logic       tx_valid, seq_err;
  logic [7:0] seq_led;

  adder_cmd_seq #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .Gl_rst(Gl_rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .adder_data(adder_data), .adder_rdy(adder_rdy),
    .tx_busy(tx_busy),
    .seq_r1(seq_r1), .seq_r2(seq_r2),
    .seq_subtract(seq_subtract), .seq_start(seq_start),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .seq_err(seq_err), .seq_led(seq_led)
  );

  typedef struct {
    logic [7:0] d;
    int         lat;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   start_cnt = 0;
  int   model_delay = 5;
  logic [7:0] model_data = 8'h30;
  logic model_en = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push(logic [7:0] d, int lat, logic err);
    exp_t e;
    e.d = d; e.lat = lat; e.err = err;
    q.push_back(e);
`ifdef SEQ_CRLF_EN
    e.d = 8'h0D; e.lat = -1; q.push_back(e);
    e.d = 8'h0A; q.push_back(e);
`endif
  endtask

  // Monitor
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (seq_start) begin
      start_cnt++;
      start_cyc = cyc;
    end
    if (tx_valid) begin
      chk("tx_while_busy", {31'd0, tx_busy}, 0);
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=%0h required=none", tx_data);
      end else begin
        e = q.pop_front();
        chk("tx_data", {24'd0, tx_data}, {24'd0, e.d});
        if (e.lat >= 0)
          chk("tx_latency", cyc - start_cyc, e.lat);
        chk("tx_err", {31'd0, seq_err}, {31'd0, e.err});
      end
    end
  end

  // Adder model
  initial forever begin
    @(negedge clk);
    if (seq_start && model_en) begin
      repeat (model_delay) @(posedge clk);
      #1;
      adder_data = model_data;
      adder_rdy  = 1'b1;
      @(posedge clk);
      #1 adder_rdy = 1'b0;
    end
  end

  task automatic send_byte(logic [7:0] b);
    @(posedge clk);
    #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic send_str(string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    chk("drain_left", q.size(), 0);
    q.delete();
  endtask

  task automatic chk_reset_vals(string tag);
    @(negedge clk);
    chk({tag, "_r1"}, {24'd0, seq_r1}, 32'h30);
    chk({tag, "_r2"}, {24'd0, seq_r2}, 32'h30);
    chk({tag, "_sub"}, {31'd0, seq_subtract}, 0);
    chk({tag, "_start"}, {31'd0, seq_start}, 0);
    chk({tag, "_txv"}, {31'd0, tx_valid}, 0);
    chk({tag, "_txd"}, {24'd0, tx_data}, 0);
    chk({tag, "_err"}, {31'd0, seq_err}, 0);
    chk({tag, "_led"}, {24'd0, seq_led}, 0);
  endtask

  initial begin
    int sc;
    Gl_rst = 1'b1;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    adder_data = 8'h00;
    adder_rdy = 1'b0;
    tx_busy = 1'b0;
    repeat (2) @(posedge clk);
    chk_reset_vals("rst");
    @(posedge clk);
    #1 Gl_rst = 1'b0;

    // 3+4
    model_data = 8'h37;
    push(8'h37, 6, 1'b0);
    send_str("3+4");
    @(negedge clk);
    chk("a_r1", {24'd0, seq_r1}, 32'h33);
    chk("a_r2", {24'd0, seq_r2}, 32'h34);
    chk("a_sub", {31'd0, seq_subtract}, 0);
    chk("a_start", {31'd0, seq_start}, 1);
    drain();

    // 7 - 2 with spaces
    model_data = 8'h35;
    push(8'h35, 6, 1'b0);
    send_str("7 - 2");
    @(negedge clk);
    chk("b_r1", {24'd0, seq_r1}, 32'h37);
    chk("b_r2", {24'd0, seq_r2}, 32'h32);
    chk("b_sub", {31'd0, seq_subtract}, 1);
    drain();

    // 3x error, then 1+1
    sc = start_cnt;
    send_str("3x");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("c_err", {31'd0, seq_err}, 1);
    chk("c_state", {29'd0, seq_led[6:4]}, 0);
    chk("c_nostart", start_cnt, sc);
    model_data = 8'h32;
    push(8'h32, 6, 1'b0);
    send_str("1+1");
    drain();

    // 5+5 timeout
    model_en = 1'b0;
    push(8'h3F, TO + 1, 1'b1);
    send_str("5+5");
    drain();
    chk("d_err", {31'd0, seq_err}, 1);
    model_en = 1'b1;

    // tx_busy across rdy, extra rx dropped
    model_data = 8'h38;
    push(8'h38, -1, 1'b0);
    send_str("4+4");
    tx_busy = 1'b1;
    send_str("9+");
    repeat (6) @(posedge clk);
    #1 tx_busy = 1'b0;
    drain();
    @(negedge clk);
    chk("e_err", {31'd0, seq_err}, 0);
    chk("e_state", {29'd0, seq_led[6:4]}, 0);

    // reset during WAIT_RDY
    model_data = 8'h37;
    send_str("6+1");
    repeat (3) @(posedge clk);
    #1 Gl_rst = 1'b1;
    @(posedge clk);
    #1 Gl_rst = 1'b0;
    repeat (4) @(posedge clk);
    chk_reset_vals("f");
    model_data = 8'h35;
    push(8'h35, 6, 1'b0);
    send_str("2+3");
    drain();

    chk("start_count", start_cnt, 7);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=done");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adder_cmd_seq.md
Name: adder_cmd_seq

Overview:
- Front-end sequencer that drives the 4-bit ASCII adder/subtractor datapath from a received character stream.
- Parses "<digit><op><digit>" commands from the RX byte interface, presents operands, subtract flag and a start pulse to the adder, then waits for the adder's ready pulse.
- Captures the adder's ASCII result and hands it to the TX byte interface.
- Sits between the UART RX/TX glue and the adder: the initiator/consumer end of the adder's start/ready protocol.

Parameters:
- TIMEOUT_CYC, 15, max cycles to wait for adder_rdy after the start pulse before declaring a fault (valid range 1..255).

Ports:
- clk  input  1  global clock
- Gl_rst  input  1  reset; synchronous, active-high
- rx_data  input  8  received ASCII byte
- rx_valid  input  1  one-cycle pulse; rx_data valid
- adder_data  input  8  ASCII result from the adder
- adder_rdy  input  1  one-cycle ready pulse from the adder
- tx_busy  input  1  TX side cannot accept a byte
- seq_r1  output  8  operand 1 (ASCII digit) to the adder
- seq_r2  output  8  operand 2 (ASCII digit) to the adder
- seq_subtract  output  1  1 = subtract, 0 = add
- seq_start  output  1  one-cycle start pulse to the adder
- tx_data  output  8  byte to transmit
- tx_valid  output  1  one-cycle pulse; tx_data valid
- seq_err  output  1  sticky error flag
- seq_led  output  8  {seq_err, state[2:0], result[3:0]}

Behaviour:
- Reset (Gl_rst high at a posedge) from any state, including mid-WAIT_RDY or mid-SEND:
  - state = GET_R1
  - seq_r1 = seq_r2 = 8'h30, seq_subtract = 0
  - seq_start = tx_valid = 0, tx_data = 8'h00
  - seq_err = 0, result register = 8'h30
  - any late adder_rdy is ignored.
- Character classes:
  - digit: 8'h30..8'h39
  - op: '+' 8'h2B, '-' 8'h2D
  - space 8'h20: ignored in every parsing state.
- Parsing states:
  - GET_R1: on rx_valid with a digit, latch seq_r1 and go to GET_OP. Any other non-space byte: set seq_err, stay.
  - GET_OP: '+' sets seq_subtract = 0, '-' sets seq_subtract = 1; either goes to GET_R2. Any other non-space byte: set seq_err, return to GET_R1.
  - GET_R2: on a digit, latch seq_r2 and go to START. Otherwise set seq_err, return to GET_R1.
- START: assert seq_start for exactly 1 cycle; clear the timeout counter; go to WAIT_RDY.
- WAIT_RDY:
  - seq_r1, seq_r2 and seq_subtract are held stable from START until adder_rdy is sampled.
  - On adder_rdy: capture adder_data into the result register, clear seq_err, go to SEND.
  - When the counter reaches TIMEOUT_CYC without adder_rdy: result = 8'h3F ('?'), set seq_err, go to SEND.
  - adder_rdy arriving in the same cycle as the timeout: rdy wins.
- SEND: wait while tx_busy = 1. First cycle with tx_busy = 0: tx_data = result, tx_valid = 1 for one cycle. Then go to GET_R1, or to CR when SEQ_CRLF_EN is defined.
- rx_valid during START, WAIT_RDY or SEND: byte dropped, no error.
- adder_rdy outside WAIT_RDY: ignored.
- Latency: third command char accepted → seq_start at +1 cycle. adder_rdy → tx_valid at +1 cycle when tx_busy = 0.
- seq_led[6:4] state encoding: GET_R1 = 0, GET_OP = 1, GET_R2 = 2, START = 3, WAIT_RDY = 4, SEND = 5, CR = 6, LF = 7.

Optional Feature:
- Macro SEQ_CRLF_EN.
- When defined:
  - After the result byte, CR then LF emit 8'h0D then 8'h0A.
  - Each byte obeys the tx_busy rule (wait while busy, one-cycle tx_valid).
  - Then return to GET_R1.
  - rx bytes are dropped during CR and LF.
- When undefined: SEND returns directly to GET_R1; the CR and LF states are absent.

Test Plan:
- RX "3+4", adder model returns 8'h37 with rdy 5 cycles after start → seq_r1 = 8'h33, seq_r2 = 8'h34, seq_subtract = 0, single seq_start pulse, one tx_valid with tx_data = 8'h37, seq_err = 0.
- RX "7 - 2", model returns 8'h35 → seq_subtract = 1, spaces ignored, tx_data = 8'h35. With SEQ_CRLF_EN: 8'h35, 8'h0D, 8'h0A on three tx_valid pulses.
- RX "3x" → seq_err = 1, state back at GET_R1, no seq_start. Then RX "1+1" with model 8'h32 → tx_data = 8'h32, seq_err cleared.
- RX "5+5", model never asserts rdy → tx_data = 8'h3F exactly TIMEOUT_CYC + 1 cycles after seq_start, seq_err = 1.
- tx_busy held high 10 cycles across rdy → no tx_valid while busy; exactly one pulse on the first non-busy cycle. Extra rx bytes sent during the wait are dropped.
- Gl_rst asserted 2 cycles into WAIT_RDY, then rdy arrives → no tx_valid, all outputs at reset values, next "2+3" processes normally.
